store_drain_buffer: RTL and testbench

Post-commit write buffer directly downstream of the store queue. It accepts committed stores (address, data, byte enables) over a valid/ready handshake and holds them in a small circular FIFO. It drains them in program order to the data-memory write port, with one outstanding write, and waits for a write acknowledge before retiring each entry. It decouples store commit from memory latency and reports an empty indication for fence and drain logic.

---
 rtl/store_drain_buffer_pkg.sv | 37 +++
 rtl/store_drain_buffer_if.sv | 46 ++++
 rtl/store_drain_buffer_fwd_merge.sv | 57 +++++
 rtl/store_drain_buffer.sv | 150 +++++++++++++++
 tb/tb_store_drain_buffer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_drain_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_drain_buffer_pkg
// Shared types for the post-commit store drain buffer.
//   sdb_state_t : drain FSM states (IDLE, REQ, RESP)
//   sdb_entry_t : one buffered store (valid, addr, data, byte enables)
// Store address/data widths come from ADDR_WIDTH / DATA_WIDTH, which the
// project normally provides through constants.vh; fallbacks are given here
// so the file also elaborates on its own.
// Optional feature macro used elsewhere in this slice: STORE_DRAIN_FWD_EN.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package store_drain_buffer_pkg;

  localparam int SDB_ADDR_W = `ADDR_WIDTH;
  localparam int SDB_DATA_W = `DATA_WIDTH;
  localparam int SDB_BE_W   = SDB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } sdb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [SDB_ADDR_W-1:0] addr;
    logic [SDB_DATA_W-1:0] data;
    logic [SDB_BE_W-1:0]   be;
  } sdb_entry_t;

endpackage

// File: rtl/store_drain_buffer_if.sv
// ---------------------------------------------------------------------------
// store_drain_buffer_if
// Bundles the store-queue side (in_*) and the data-memory write port side
// (mem_*) of the store drain buffer.
//   slave  : the buffer's view (accepts stores, issues memory writes)
//   master : the environment's view (offers stores, services writes)
// Parameters ADDR_W / DATA_W default to ADDR_WIDTH / DATA_WIDTH.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface store_drain_buffer_if #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
);

  localparam int BE_W = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [BE_W-1:0]   in_be;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;

  modport slave (
    input  in_valid, in_addr, in_data, in_be, mem_req_ready, mem_ack,
    output in_ready, mem_req_valid, mem_addr, mem_data, mem_be
  );

  modport master (
    output in_valid, in_addr, in_data, in_be, mem_req_ready, mem_ack,
    input  in_ready, mem_req_valid, mem_addr, mem_data, mem_be
  );

endinterface

// File: rtl/store_drain_buffer_fwd_merge.sv
// ---------------------------------------------------------------------------
// sdb_fwd_merge
// Combinational load-forwarding lookup over the drain buffer contents.
// Only instantiated when STORE_DRAIN_FWD_EN is defined.
// Ports:
//   entries  : buffer storage, indexed by physical slot
//   head     : slot of the oldest entry (age 0)
//   fwd_addr : load address; low byte-offset bits are ignored
//   fwd_hit  : at least one byte forwarded
//   fwd_data : merged bytes, youngest matching store wins per byte
//   fwd_be   : which bytes of fwd_data are valid
// ---------------------------------------------------------------------------
module sdb_fwd_merge
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SDB_ADDR_W,
  parameter int DATA_W = SDB_DATA_W
) (
  input  sdb_entry_t                 entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [DATA_W/8-1:0]        fwd_be
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic [PTR_W-1:0]  idx;
  logic [ADDR_W-1:0] entry_addr;

  // Walk from oldest to youngest so a younger match overwrites older bytes.
  always_comb begin
    fwd_data   = '0;
    fwd_be     = '0;
    idx        = '0;
    entry_addr = '0;
    for (int age = 0; age < DEPTH; age++) begin
      idx        = head + PTR_W'(age);
      entry_addr = ADDR_W'(entries[idx].addr);
      if (entries[idx].valid && ((entry_addr >> OFF_W) == (fwd_addr >> OFF_W))) begin
        for (int b = 0; b < BE_W; b++) begin
          if (entries[idx].be[b]) begin
            fwd_data[8*b +: 8] = entries[idx].data[8*b +: 8];
            fwd_be[b]          = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_hit = |fwd_be;

endmodule

// File: rtl/store_drain_buffer.sv
// ---------------------------------------------------------------------------
// store_drain_buffer
// Post-commit write buffer behind the store queue. Committed stores are held
// in a circular FIFO and written to data memory in program order, one write
// outstanding at a time; an entry retires only when its write is acked.
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   bus        : store_drain_buffer_if.slave (in_* store side, mem_* write port)
//   count      : occupied entries
//   empty      : no entries and drain FSM idle (for fence/drain logic)
// Optional (macro STORE_DRAIN_FWD_EN): fwd_addr/fwd_hit/fwd_data/fwd_be,
// a zero-latency load-forwarding lookup over all buffered stores.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  store_drain_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
`ifdef STORE_DRAIN_FWD_EN
  ,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [DATA_W/8-1:0]      fwd_be
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sdb_entry_t       entries_q [DEPTH];
  sdb_entry_t       entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  sdb_state_t       state_q, state_d;

  logic       in_ready;
  logic       push;
  logic       pop;
  logic       req_active;
  sdb_entry_t head_entry;

  // No same-cycle bypass: readiness depends on the registered count only.
  assign in_ready = (count_q < FULL_CNT);
  assign push     = bus.in_valid && in_ready;
  assign pop      = (state_q == RESP) && bus.mem_ack;

  // Storage update and drain FSM. The head slot is never written here while
  // it is being requested, since a push only lands at head when count is 0.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    state_d   = state_q;

    if (push) begin
      entries_d[tail_q] = '{valid: 1'b1,
                            addr:  bus.in_addr,
                            data:  bus.in_data,
                            be:    bus.in_be};
      tail_d = tail_q + PTR_W'(1);
    end

    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = REQ;
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (pop) state_d = (count_d != '0) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  // Request fields are forced to zero outside REQ so reset and idle look clean.
  assign head_entry        = entries_q[head_q];
  assign req_active        = (state_q == REQ) && head_entry.valid;
  assign bus.in_ready      = in_ready;
  assign bus.mem_req_valid = req_active;
  assign bus.mem_addr      = req_active ? ADDR_W'(head_entry.addr) : '0;
  assign bus.mem_data      = req_active ? DATA_W'(head_entry.data) : '0;
  assign bus.mem_be        = req_active ? BE_W'(head_entry.be)     : '0;

  assign count = count_q;
  assign empty = (count_q == '0) && (state_q == IDLE);

`ifdef STORE_DRAIN_FWD_EN
  sdb_fwd_merge #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_merge (
    .entries  (entries_q),
    .head     (head_q),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .fwd_be   (fwd_be)
  );
`endif

  // A write acknowledge is only meaningful while a write is outstanding.
  ack_only_in_resp: assert property (@(posedge clk) disable iff (!reset)
    bus.mem_ack |-> (state_q == RESP));

endmodule

// File: tb/tb_store_drain_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_drain_buffer
// Directed and randomized stimulus for store_drain_buffer. A queue of pending
// stores models the buffer: stores join on an accepted push and leave on the
// memory acknowledge, so count, in_ready, empty and the request fields all
// follow from the queue contents. A small memory responder accepts requests
// and acknowledges them after a chosen delay.
// ---------------------------------------------------------------------------
module tb_store_drain_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = store_drain_buffer_pkg::SDB_ADDR_W;
  localparam int DW    = store_drain_buffer_pkg::SDB_DATA_W;
  localparam int BW    = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } store_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;

`ifdef STORE_DRAIN_FWD_EN
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [BW-1:0] fwd_be;
`endif

  store_drain_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  store_drain_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .count    (count),
    .empty    (empty)
`ifdef STORE_DRAIN_FWD_EN
    ,
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .fwd_be   (fwd_be)
`endif
  );

  always #5 clk = ~clk;

  store_t model_q[$];
  int     total = 0;
  int     bad = 0;
  int     rdy_mode = 1;
  int     ack_delay = 2;
  int     ack_timer = 0;
  bit     outstanding = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the handshakes that happen at the coming edge.
  task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [BW-1:0] be);
    bit     rdy;
    bit     ack;
    bit     push;
    bit     accepted;
    store_t f;
    if (rdy_mode == 2) rdy = 1'($urandom_range(0, 1));
    else               rdy = (rdy_mode == 1);
    ack = (ack_timer == 1);
    bus.in_valid      = v;
    bus.in_addr       = a;
    bus.in_data       = d;
    bus.in_be         = be;
    bus.mem_req_ready = rdy;
    bus.mem_ack       = ack;
    #1;
    checkOutput("count", 64'(count), 64'(model_q.size()));
    checkOutput("in_ready", 64'(bus.in_ready), 64'(model_q.size() < DEPTH));
    checkOutput("empty", 64'(empty), 64'(model_q.size() == 0));
    if (outstanding || model_q.size() == 0) begin
      checkOutput("req_valid_quiet", 64'(bus.mem_req_valid), 64'd0);
    end else if (bus.mem_req_valid) begin
      f = model_q[0];
      checkOutput("mem_addr", 64'(bus.mem_addr), 64'(f.addr));
      checkOutput("mem_data", 64'(bus.mem_data), 64'(f.data));
      checkOutput("mem_be", 64'(bus.mem_be), 64'(f.be));
    end
    push     = v && (model_q.size() < DEPTH);
    accepted = bus.mem_req_valid && rdy;
    if (ack) begin
      void'(model_q.pop_front());
      outstanding = 1'b0;
    end
    if (push) model_q.push_back('{addr: a, data: d, be: be});
    if (ack_timer > 0) ack_timer--;
    if (accepted) begin
      outstanding = 1'b1;
      ack_timer   = (ack_delay == 0) ? int'($urandom_range(1, 4)) : ack_delay;
    end
    @(posedge clk);
    #1;
  endtask

  // Idle cycles until every buffered store has been written and acked.
  task automatic drainAll(input int bound);
    for (int i = 0; i < bound && (model_q.size() != 0 || outstanding); i++)
      applyStimulus(1'b0, '0, '0, '0);
    checkOutput("drain_done", 64'(model_q.size()), 64'd0);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("drain_count", 64'(count), 64'd0);
    checkOutput("drain_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_addr       = '0;
    bus.in_data       = '0;
    bus.in_be         = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_ack       = 1'b0;
`ifdef STORE_DRAIN_FWD_EN
    fwd_addr = '0;
`endif

    // Reset values
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("rst_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("rst_data", 64'(bus.mem_data), 64'd0);
    checkOutput("rst_be", 64'(bus.mem_be), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single store: request two cycles after the push, acked two cycles later
    $display("[TB] single store");
    rdy_mode  = 1;
    ack_delay = 2;
    applyStimulus(1'b1, AW'(32'h100), DW'(32'hDEADBEEF), BW'(4'hF));
    checkOutput("lat_n1_valid", 64'(bus.mem_req_valid), 64'd0);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("lat_n2_valid", 64'(bus.mem_req_valid), 64'd1);
    checkOutput("lat_n2_addr", 64'(bus.mem_addr), 64'h100);
    checkOutput("lat_n2_data", 64'(bus.mem_data), 64'hDEADBEEF);
    drainAll(20);

    // Fill with the memory stalled; the fifth store must be dropped
    $display("[TB] fill and backpressure");
    rdy_mode = 0;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, AW'(32'h1000 + 16 * i), DW'(32'hA000_0000 + i), BW'(4'hF));
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);

    // Drain in order with acks three cycles after acceptance
    $display("[TB] drain in order");
    rdy_mode  = 1;
    ack_delay = 3;
    drainAll(100);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, AW'(32'h2000 + 4 * i), DW'(32'hB000_0000 + i), BW'(i + 1));
    drainAll(100);

    // Push coinciding with the ack while two stores are buffered
    $display("[TB] simultaneous push and ack");
    applyStimulus(1'b1, AW'(32'h3000), DW'(32'h1111_1111), BW'(4'hF));
    applyStimulus(1'b1, AW'(32'h3004), DW'(32'h2222_2222), BW'(4'h3));
    for (int i = 0; i < 20 && !(ack_timer == 1 && model_q.size() == 2); i++)
      applyStimulus(1'b0, '0, '0, '0);
    checkOutput("simul_setup", 64'(ack_timer == 1 && model_q.size() == 2), 64'd1);
    applyStimulus(1'b1, AW'(32'h3008), DW'(32'h3333_3333), BW'(4'h0));
    checkOutput("simul_count", 64'(count), 64'd2);
    for (int i = 0; i < 20 && !bus.mem_req_valid; i++)
      applyStimulus(1'b0, '0, '0, '0);
    checkOutput("simul_next_valid", 64'(bus.mem_req_valid), 64'd1);
    checkOutput("simul_next_addr", 64'(bus.mem_addr), 64'h3004);
    drainAll(100);

    // Randomized traffic with random ready and ack delays
    $display("[TB] random traffic");
    rdy_mode  = 2;
    ack_delay = 0;
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom()), DW'($urandom()),
                    BW'($urandom_range(0, 15)));
    rdy_mode = 1;
    drainAll(200);

    // Reset while a write is outstanding; an ack during reset is ignored
    $display("[TB] reset mid-RESP");
    ack_delay = 30;
    applyStimulus(1'b1, AW'(32'h4000), DW'(32'h4444_4444), BW'(4'hF));
    applyStimulus(1'b1, AW'(32'h4004), DW'(32'h5555_5555), BW'(4'hF));
    for (int i = 0; i < 10 && ack_timer == 0; i++)
      applyStimulus(1'b0, '0, '0, '0);
    checkOutput("rst2_setup", 64'(outstanding), 64'd1);
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b1;
    reset        = 1'b0;
    #1;
    checkOutput("rst2_req_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("rst2_count", 64'(count), 64'd0);
    checkOutput("rst2_empty", 64'(empty), 64'd1);
    checkOutput("rst2_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst2_addr", 64'(bus.mem_addr), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst2_count_hold", 64'(count), 64'd0);
    reset       = 1'b1;
    bus.mem_ack = 1'b0;
    model_q.delete();
    outstanding = 1'b0;
    ack_timer   = 0;
    repeat (3) applyStimulus(1'b0, '0, '0, '0);
    ack_delay = 1;
    applyStimulus(1'b1, AW'(32'h5000), DW'(32'h6666_6666), BW'(4'h9));
    drainAll(20);

`ifdef STORE_DRAIN_FWD_EN
    // Forwarding: younger partial store overrides the upper bytes
    $display("[TB] load forwarding");
    rdy_mode = 0;
    applyStimulus(1'b1, AW'(32'h200), DW'(32'h11223344), BW'(4'hF));
    applyStimulus(1'b1, AW'(32'h200), DW'(32'hAABB0000), BW'(4'b1100));
    fwd_addr = AW'(32'h202);
    #1;
    checkOutput("fwd_hit", 64'(fwd_hit), 64'd1);
    checkOutput("fwd_be", 64'(fwd_be), 64'hF);
    checkOutput("fwd_data", 64'(fwd_data), 64'hAABB3344);
    fwd_addr = AW'(32'h300);
    #1;
    checkOutput("fwd_miss", 64'(fwd_hit), 64'd0);
    rdy_mode  = 1;
    ack_delay = 2;
    drainAll(50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
